// File: rtl/countdown_timer_core_if.sv
// Control/status bundle for the countdown timer core.
// All controls are levels sampled on every rising clk edge; there is no valid/ready handshake.
interface countdown_timer_core_if;
    logic       load;
    logic [6:0] preset_min;
    logic [5:0] preset_sec;
    logic       start;
    logic       pause;
    logic [6:0] min_out;
    logic [5:0] sec_out;
    logic       running;
    logic       done;
    logic       expired;
    logic [1:0] state_dbg;

    modport master (
        output load, preset_min, preset_sec, start, pause,
        input  min_out, sec_out, running, done, expired, state_dbg
    );

    modport slave (
        input  load, preset_min, preset_sec, start, pause,
        output min_out, sec_out, running, done, expired, state_dbg
    );
endinterface

// File: rtl/countdown_timer_core.sv
// Countdown mm:ss timer driven by a down-counting 1 Hz prescaler.
// Optional AUTO_RELOAD_EN: on expiry reload the stored preset and keep running.
module countdown_timer_core #(
    parameter int TICK_DIV = 25_000_000,
    parameter int PRESC_W  = 25
) (
    input  logic                   clk,
    input  logic                   rst,
    countdown_timer_core_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [PRESC_W-1:0] RELOAD = PRESC_W'(TICK_DIV - 1);

    state_t             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [6:0]         min_q, min_d;
    logic [5:0]         sec_q, sec_d;
    logic               running_q, running_d;
    logic               done_q, done_d;
    logic               expired_q, expired_d;
`ifdef AUTO_RELOAD_EN
    logic [6:0]         pmin_q, pmin_d;
    logic [5:0]         psec_q, psec_d;
`endif

    logic [6:0] min_clamped;
    logic [5:0] sec_clamped;
    logic       tick;
    logic       time_zero;
    logic       expiring;

    always_comb begin
        min_clamped = (bus.preset_min > 7'd99) ? 7'd99 : bus.preset_min;
        sec_clamped = (bus.preset_sec > 6'd59) ? 6'd59 : bus.preset_sec;
        tick        = (presc_q == '0);
        time_zero   = (min_q == 7'd0) && (sec_q == 6'd0);
        // Only 00:01 can reach 00:00 on a tick; 01:00 borrows to 00:59.
        expiring    = (min_q == 7'd0) && (sec_q == 6'd1);
    end

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        min_d     = min_q;
        sec_d     = sec_q;
        done_d    = 1'b0;
        expired_d = expired_q;
`ifdef AUTO_RELOAD_EN
        pmin_d    = pmin_q;
        psec_d    = psec_q;
`endif

        if (bus.load) begin
            min_d     = min_clamped;
            sec_d     = sec_clamped;
            presc_d   = RELOAD;
            expired_d = 1'b0;
            state_d   = ST_IDLE;
`ifdef AUTO_RELOAD_EN
            pmin_d    = min_clamped;
            psec_d    = sec_clamped;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && !bus.pause && !time_zero) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (bus.pause) begin
                        state_d = ST_PAUSE;
                    end else if (!tick) begin
                        presc_d = presc_q - 1'b1;
                    end else begin
                        presc_d = RELOAD;
                        if (sec_q != 6'd0) begin
                            sec_d = sec_q - 6'd1;
                        end else if (min_q != 7'd0) begin
                            min_d = min_q - 7'd1;
                            sec_d = 6'd59;
                        end
                        if (expiring) begin
                            done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
                            if ((pmin_q != 7'd0) || (psec_q != 6'd0)) begin
                                min_d = pmin_q;
                                sec_d = psec_q;
                            end else begin
                                expired_d = 1'b1;
                                state_d   = ST_DONE;
                            end
`else
                            expired_d = 1'b1;
                            state_d   = ST_DONE;
`endif
                        end
                    end
                end
                ST_PAUSE: begin
                    if (bus.start && !bus.pause) state_d = ST_RUN;
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            presc_q   <= RELOAD;
            min_q     <= 7'd0;
            sec_q     <= 6'd0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
`ifdef AUTO_RELOAD_EN
            pmin_q    <= 7'd0;
            psec_q    <= 6'd0;
`endif
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            running_q <= running_d;
            done_q    <= done_d;
            expired_q <= expired_d;
`ifdef AUTO_RELOAD_EN
            pmin_q    <= pmin_d;
            psec_q    <= psec_d;
`endif
        end
    end

    assign bus.min_out   = min_q;
    assign bus.sec_out   = sec_q;
    assign bus.running   = running_q;
    assign bus.done      = done_q;
    assign bus.expired   = expired_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_countdown_timer_core.sv
// Bench for countdown_timer_core with TICK_DIV=4: a seconds-count model checked every
// cycle, plus literal checkpoints for the directed scenarios.
module tb_countdown_timer_core;
    localparam int TICK_DIV = 4;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    typedef struct packed {
        int   st;
        int   total;
        int   phase;
        int   preset;
        logic done;
        logic expired;
    } mdl_t;

    logic clk;
    logic rst;
    logic chk_en;
    int   checks;
    int   errors;
    mdl_t mdl;

    countdown_timer_core_if bus ();

    countdown_timer_core #(
        .TICK_DIV(TICK_DIV),
        .PRESC_W (25)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    // Model: time kept as total seconds, tick after TICK_DIV run clocks.
    function automatic mdl_t model_step(mdl_t m, logic r, logic ld, int pm, int ps,
                                        logic st_in, logic pa);
        mdl_t n;
        n = m;
        n.done = 1'b0;
        if (r) begin
            n = '0;
            n.st = M_IDLE;
        end else if (ld) begin
            n.preset  = ((pm > 99) ? 99 : pm) * 60 + ((ps > 59) ? 59 : ps);
            n.total   = n.preset;
            n.phase   = 0;
            n.expired = 1'b0;
            n.st      = M_IDLE;
        end else if (m.st == M_IDLE) begin
            if (st_in && !pa && m.total != 0) n.st = M_RUN;
        end else if (m.st == M_PAUSE) begin
            if (st_in && !pa) n.st = M_RUN;
        end else if (m.st == M_RUN) begin
            if (pa) begin
                n.st = M_PAUSE;
            end else if (m.phase + 1 < TICK_DIV) begin
                n.phase = m.phase + 1;
            end else begin
                n.phase = 0;
                n.total = m.total - 1;
                if (n.total == 0) begin
                    n.done = 1'b1;
`ifdef AUTO_RELOAD_EN
                    if (m.preset != 0) begin
                        n.total = m.preset;
                    end else begin
                        n.expired = 1'b1;
                        n.st      = M_DONE;
                    end
`else
                    n.expired = 1'b1;
                    n.st      = M_DONE;
`endif
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk)
        mdl <= model_step(mdl, rst, bus.load, int'(bus.preset_min), int'(bus.preset_sec),
                          bus.start, bus.pause);

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // scoreboard: every cycle once reset has been applied
    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_min",     int'(bus.min_out), mdl.total / 60);
            check("mdl_sec",     int'(bus.sec_out), mdl.total % 60);
            check("mdl_running", int'(bus.running), (mdl.st == M_RUN) ? 1 : 0);
            check("mdl_done",    int'(bus.done),    int'(mdl.done));
            check("mdl_expired", int'(bus.expired), int'(mdl.expired));
        end
    end

    // driver tasks
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_time(input int m, input int s);
        bus.preset_min = 7'(m);
        bus.preset_sec = 6'(s);
        bus.load = 1'b1;
        cyc(1);
        bus.load = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        chk_en = 1'b0;
        mdl = '0;
        rst = 1'b1;
        bus.load = 1'b0;
        bus.preset_min = 7'd0;
        bus.preset_sec = 6'd0;
        bus.start = 1'b0;
        bus.pause = 1'b0;

        // 1. reset
        cyc(2);
        check("rst_min",     int'(bus.min_out), 0);
        check("rst_sec",     int'(bus.sec_out), 0);
        check("rst_running", int'(bus.running), 0);
        check("rst_done",    int'(bus.done),    0);
        check("rst_expired", int'(bus.expired), 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // 2. 00:03 countdown to expiry
        load_time(0, 3);
        check("ld3_sec", int'(bus.sec_out), 3);
        pulse_start();
        check("t2_run", int'(bus.running), 1);
        cyc(3);
        check("t2_sec_n3", int'(bus.sec_out), 3);
        cyc(1);
        check("t2_sec_n4", int'(bus.sec_out), 2);
        cyc(4);
        check("t2_sec_n8", int'(bus.sec_out), 1);
        cyc(3);
        check("t2_done_n11", int'(bus.done), 0);
        cyc(1);
        check("t2_done_n12", int'(bus.done), 1);
`ifndef AUTO_RELOAD_EN
        check("t2_sec_n12",  int'(bus.sec_out), 0);
        check("t2_exp_n12",  int'(bus.expired), 1);
        check("t2_run_n12",  int'(bus.running), 0);
        cyc(1);
        check("t2_done_n13", int'(bus.done), 0);
        bus.start = 1'b1;
        cyc(3);
        bus.start = 1'b0;
        check("t2_hold_sec", int'(bus.sec_out), 0);
        check("t2_hold_run", int'(bus.running), 0);
        check("t2_hold_exp", int'(bus.expired), 1);
`endif

        // 3. minute borrow
        load_time(1, 0);
        check("t3_exp_clr", int'(bus.expired), 0);
        pulse_start();
        cyc(4);
        check("t3_min", int'(bus.min_out), 0);
        check("t3_sec", int'(bus.sec_out), 59);

        // 4. pause and resume keep the prescaler remainder
        load_time(0, 5);
        pulse_start();
        cyc(2);
        bus.pause = 1'b1;
        cyc(10);
        check("t4_paused_run", int'(bus.running), 0);
        check("t4_paused_sec", int'(bus.sec_out), 5);
        bus.pause = 1'b0;
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        check("t4_resume_run", int'(bus.running), 1);
        cyc(1);
        check("t4_sec_r1", int'(bus.sec_out), 5);
        cyc(1);
        check("t4_sec_r2", int'(bus.sec_out), 4);

        // 5. start+pause in IDLE, zero preset, clamping
        load_time(0, 7);
        bus.start = 1'b1;
        bus.pause = 1'b1;
        cyc(3);
        bus.start = 1'b0;
        bus.pause = 1'b0;
        check("t5_sp_run", int'(bus.running), 0);
        check("t5_sp_sec", int'(bus.sec_out), 7);
        load_time(0, 0);
        bus.start = 1'b1;
        cyc(8);
        bus.start = 1'b0;
        check("t5_zero_run",  int'(bus.running), 0);
        check("t5_zero_done", int'(bus.done),    0);
        load_time(120, 63);
        check("t5_clamp_min", int'(bus.min_out), 99);
        check("t5_clamp_sec", int'(bus.sec_out), 59);

        // rst mid-count drops the preset too
        load_time(2, 30);
        pulse_start();
        cyc(5);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("rst_mid_min", int'(bus.min_out), 0);
        check("rst_mid_sec", int'(bus.sec_out), 0);
        pulse_start();
        cyc(2);
        check("rst_mid_run", int'(bus.running), 0);

`ifdef AUTO_RELOAD_EN
        // 6. auto reload on expiry
        load_time(0, 2);
        pulse_start();
        cyc(8);
        check("t6_done",    int'(bus.done),    1);
        check("t6_sec",     int'(bus.sec_out), 2);
        check("t6_run",     int'(bus.running), 1);
        check("t6_expired", int'(bus.expired), 0);
        cyc(3);
        check("t6_sec_n11", int'(bus.sec_out), 2);
        cyc(1);
        check("t6_sec_n12", int'(bus.sec_out), 1);
`endif

        cyc(2);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
